// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with decode-side buffer; IFETCH_SKID_EN selects a 2-entry buffer
module fetch_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pcaddr,
    input  logic [31:0] nxt_pc,
    output logic        PC_EN,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        flush,
    input  logic        halt,
    input  logic        id_stall,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out
);

`ifdef IFETCH_SKID_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [31:0] drain_addr;
    logic        pop;
    logic        free;
    logic        push;
    logic        kill;

`ifdef IFETCH_SKID_EN
    logic [31:0] e1_instr;
    logic [31:0] e1_pc;
    logic [31:0] e1_npc;
`endif

    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && !id_stall;
    assign free      = (count - {1'b0, pop}) < DEPTH;
    // Once halted the stage no longer reacts to redirects.
    assign kill      = flush && (state != HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A returned word is only consumed when a slot is free; otherwise the
    // request stays asserted at the same address and is re-read.
    always_comb begin
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        PC_EN    = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: begin
                PC_EN = flush;
            end
            REQ: begin
                imemREN  = 1'b1;
                imemaddr = pcaddr;
                push     = ihit && !flush && free;
                PC_EN    = flush || push;
            end
            DRAIN: begin
                imemREN  = 1'b1;
                imemaddr = drain_addr;
                PC_EN    = flush;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        if (kill) begin
            count_nxt = 2'd0;
        end else begin
            count_nxt = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (halt) begin
                    state_nxt = HALTED;
                end else if (free) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ihit && flush) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end else if (push) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if ((count_nxt < DEPTH) || !id_stall) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (ihit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count      <= 2'd0;
            drain_addr <= 32'd0;
        end else begin
            count <= count_nxt;
            if (state == REQ && flush && !ihit) begin
                drain_addr <= pcaddr;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_out <= 32'd0;
            pc_out    <= 32'd0;
            npc_out   <= 32'd0;
`ifdef IFETCH_SKID_EN
            e1_instr  <= 32'd0;
            e1_pc     <= 32'd0;
            e1_npc    <= 32'd0;
`endif
        end else if (!kill) begin
`ifdef IFETCH_SKID_EN
            // The head takes the new word only when it would otherwise be empty.
            if (push && (count == 2'd0 || (pop && count == 2'd1))) begin
                instr_out <= imemload;
                pc_out    <= pcaddr;
                npc_out   <= nxt_pc;
            end else if (pop) begin
                instr_out <= e1_instr;
                pc_out    <= e1_pc;
                npc_out   <= e1_npc;
            end
            if (push) begin
                e1_instr <= imemload;
                e1_pc    <= pcaddr;
                e1_npc   <= nxt_pc;
            end
`else
            if (push) begin
                instr_out <= imemload;
                pc_out    <= pcaddr;
                npc_out   <= nxt_pc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pcaddr;
    logic [31:0] nxt_pc;
    logic        PC_EN;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        halt;
    logic        id_stall;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic [31:0] tgt;

    int checks = 0;
    int fails  = 0;

    fetch_stage dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .pcaddr    (pcaddr),
        .nxt_pc    (nxt_pc),
        .PC_EN     (PC_EN),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .flush     (flush),
        .halt      (halt),
        .id_stall  (id_stall),
        .valid_out (valid_out),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .npc_out   (npc_out)
    );

    always #5 CLK = ~CLK;

    // Program counter model: advances by 4, or to tgt on a redirect.
    assign nxt_pc = pcaddr + 32'd4;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pcaddr <= 32'd0;
        end else if (PC_EN) begin
            pcaddr <= flush ? tgt : nxt_pc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ih, input logic fl, input logic hl, input logic st,
                          input logic [31:0] ld, input logic [31:0] tg);
        ihit = ih; flush = fl; halt = hl; id_stall = st; imemload = ld; tgt = tg;
    endtask

    // Leaves the bench at a falling edge with reset just released (stage in IDLE).
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        chk("rst_addr", imemaddr, 32'd0);
        chk("rst_pcen", {31'd0, PC_EN}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_npc", npc_out, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic        ih;
        logic        fl;
        logic        st;
        logic [31:0] load;
        logic [31:0] tg;
        logic        ren;
        logic [31:0] addr;
        logic        pcen;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int          pops;
        logic [31:0] exp_pc;
        logic        found;

        nRST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Streaming, flush with ihit, memory wait, flush during wait, drain, restart.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'hA000_0000, 32'h0,   1'b1, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'hA000_0001, 32'h0,   1'b1, 32'h4,   1'b1, 1'b1, 32'h0,  32'hA000_0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hA000_0002, 32'h40,  1'b1, 32'h8,   1'b1, 1'b1, 32'h4,  32'hA000_0001};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'hB000_0040, 32'h0,   1'b1, 32'h40,  1'b1, 1'b0, 32'h0,  32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h100, 1'b1, 32'h44,  1'b1, 1'b1, 32'h40, 32'hB000_0040};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h44,  1'b0, 1'b0, 32'h0,  32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,   1'b1, 32'h44,  1'b0, 1'b0, 32'h0,  32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'hC000_0100, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 32'h0,  32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h104, 1'b0, 1'b1, 32'h100, 32'hC000_0100};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h104, 1'b0, 1'b0, 32'h0,  32'h0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].ih, tbl[i].fl, 1'b0, tbl[i].st, tbl[i].load, tbl[i].tg);
            #1;
            chk($sformatf("v%0d_ren", i), {31'd0, imemREN}, {31'd0, tbl[i].ren});
            chk($sformatf("v%0d_addr", i), imemaddr, tbl[i].addr);
            chk($sformatf("v%0d_pcen", i), {31'd0, PC_EN}, {31'd0, tbl[i].pcen});
            chk($sformatf("v%0d_valid", i), {31'd0, valid_out}, {31'd0, tbl[i].valid});
            if (tbl[i].valid) begin
                chk($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
                chk($sformatf("v%0d_instr", i), instr_out, tbl[i].instr);
                chk($sformatf("v%0d_npc", i), npc_out, tbl[i].pc + 32'd4);
            end
            @(negedge CLK);
        end

        // Decode stall for 4 cycles with memory always hitting.
        do_reset();
        pops   = 0;
        exp_pc = 32'd0;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'b0, 1'b0, (i >= 3 && i <= 6), {16'hD000, pcaddr[15:0]}, 32'd0);
            #1;
            if (valid_out && !id_stall) begin
                chk("stall_pop_pc", pc_out, exp_pc);
                chk("stall_pop_instr", instr_out, {16'hD000, exp_pc[15:0]});
                chk("stall_pop_npc", npc_out, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (id_stall) begin
                chk("stall_hold_pc", pc_out, 32'h4);
                chk("stall_hold_valid", {31'd0, valid_out}, 32'd1);
`ifdef IFETCH_SKID_EN
                if (i == 3) chk("stall_skid_pcen", {31'd0, PC_EN}, 32'd1);
                else        chk("stall_skid_ren", {31'd0, imemREN}, 32'd0);
`else
                chk("stall_pcen", {31'd0, PC_EN}, 32'd0);
`endif
            end
            @(negedge CLK);
        end
        chk("stall_pop_count", pops, 32'd11);

        // Halt on the hit at 0x20.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            set_in(1'b1, 1'b0, (pcaddr == 32'h20), 1'b0, {16'hE000, pcaddr[15:0]}, 32'd0);
            #1;
            if (halt) begin
                found = 1'b1;
                chk("halt_pcen", {31'd0, PC_EN}, 32'd1);
                chk("halt_addr", imemaddr, 32'h20);
            end
            @(negedge CLK);
        end
        chk("halt_reached", {31'd0, found}, 32'd1);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h80);
        #1;
        chk("halted_ren", {31'd0, imemREN}, 32'd0);
        chk("halted_pcen_flush", {31'd0, PC_EN}, 32'd0);
        chk("halted_valid", {31'd0, valid_out}, 32'd1);
        chk("halted_pc", pc_out, 32'h20);
        chk("halted_instr", instr_out, 32'hE000_0020);
        @(negedge CLK);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("halted_drained", {31'd0, valid_out}, 32'd0);
        chk("halted_ren2", {31'd0, imemREN}, 32'd0);
        chk("halted_pcen2", {31'd0, PC_EN}, 32'd0);
        @(negedge CLK);

        // Flush with a full buffer and a simultaneous hit, then reset mid-request.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 1'b0, (i >= 3), 32'h1111_0000, 32'd0);
            @(negedge CLK);
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_0000, 32'h200);
        #1;
        chk("ffull_pcen", {31'd0, PC_EN}, 32'd1);
        chk("ffull_valid_before", {31'd0, valid_out}, 32'd1);
        @(negedge CLK);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h3333_0000, 32'd0);
        #1;
        chk("ffull_valid_after", {31'd0, valid_out}, 32'd0);
        chk("ffull_idle_ren", {31'd0, imemREN}, 32'd0);
        chk("ffull_idle_addr", imemaddr, 32'd0);
        @(negedge CLK);
        #1;
        chk("ffull_req_ren", {31'd0, imemREN}, 32'd1);
        chk("ffull_req_addr", imemaddr, 32'h200);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_ren", {31'd0, imemREN}, 32'd0);
        chk("midrst_addr", imemaddr, 32'd0);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("late_ihit_ren", {31'd0, imemREN}, 32'd0);
        chk("late_ihit_pcen", {31'd0, PC_EN}, 32'd0);
        @(negedge CLK);
        #1;
        chk("late_ihit_valid", {31'd0, valid_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage between the program counter and decode. It uses the current PC to issue read requests to the instruction memory/cache and holds each request until `ihit`. Returned instructions are buffered with their PC and PC+4 for decode. It drives `PC_EN` back to the program counter, so the PC advances only when an instruction is accepted or a redirect (flush) occurs.

## Interface
Parameters:
- none: all data widths are `word_t` (32 bits, `cpu_types_pkg`); buffer depth is set by the Configuration macro.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `pcaddr` in 32: current PC from the program counter.
- `nxt_pc` in 32: `pcaddr + 4` from the program counter.
- `PC_EN` out 1: PC update enable, combinational.
- `imemREN` out 1: instruction read request.
- `imemaddr` out 32: instruction read address.
- `ihit` in 1: memory read done; `imemload` is valid in the same cycle.
- `imemload` in 32: instruction data.
- `flush` in 1: redirect from a branch/JR/jump decision. Kills buffered and in-flight fetches.
- `halt` in 1: stop issuing fetches.
- `id_stall` in 1: decode cannot consume this cycle.
- `valid_out` out 1: buffer head is valid.
- `instr_out` out 32: head instruction.
- `pc_out` out 32: head PC.
- `npc_out` out 32: head PC+4.

## Operation
- States: IDLE, REQ, DRAIN, HALTED. Reset state is IDLE.
- Buffer: FIFO of DEPTH entries, each `{instr, pc, npc}`, with a 2-bit `count`.
- Pop: occurs when `valid_out && !id_stall`.
- Free slot: `count - pop < DEPTH`.
- IDLE
  - `flush`: `PC_EN=1`, stay IDLE.
  - else if `halt`: go to HALTED.
  - else if a slot is free: go to REQ.
  - `imemREN=0`.
- REQ
  - Outputs: `imemREN=1`, `imemaddr=pcaddr`. `pcaddr` is stable because `PC_EN` is 0 until this state resolves.
  - `ihit && !flush`: push `{imemload, pcaddr, nxt_pc}` and set `PC_EN=1`. Next state: HALTED if `halt`; else REQ if a slot is still free after this push/pop; else IDLE.
  - `ihit && flush`: discard the data, `PC_EN=1`, go to IDLE.
  - `!ihit && flush`: latch `drain_addr<=pcaddr`, `PC_EN=1`, go to DRAIN.
  - `halt` without `ihit` is ignored; the request must complete first.
- DRAIN
  - Outputs: `imemREN=1`, `imemaddr=drain_addr`. The address is held until `ihit`.
  - `ihit`: discard the data, go to IDLE.
  - `flush`: `PC_EN=1`, stay in DRAIN.
- HALTED
  - `imemREN=0`, `PC_EN=0`; `flush` is ignored.
  - The buffer still drains to decode.
  - Exit is by reset only.
- `flush` clears `count` to 0 in the same edge. It has priority over push and pop.
- `imemaddr` is 0 whenever `imemREN=0`.

## Timing
- Reset values: `PC_EN=0`, `imemREN=0`, `imemaddr=0`, `valid_out=0`, `instr_out`/`pc_out`/`npc_out=0`, `count=0`, `drain_addr=0`.
- Outputs `instr_out`/`pc_out`/`npc_out` come from registered buffer storage. `valid_out = (count != 0)`.
- First request: leaving reset, `imemREN` rises 1 cycle after IDLE (IDLE→REQ edge).
- Throughput: back-to-back with same-cycle `ihit` gives 1 instruction/cycle. REQ stays REQ; the PC updates at the `ihit` edge and the next address appears the following cycle.
- Latency: data pushed on the `ihit` edge is visible on `valid_out` in the next cycle.
- Request protocol: `imemREN`/`imemaddr` never change between assertion and `ihit`.
- Reset mid-request: everything returns to reset values immediately. A late `ihit` after reset is ignored in IDLE.

## Configuration
- `IFETCH_SKID_EN` defined: DEPTH=2. Fetch continues during a 1-cycle `id_stall`.
- `IFETCH_SKID_EN` undefined: DEPTH=1. Fetch issues only when the buffer is empty or being popped that cycle.

## Test plan
- Reset with `pcaddr=0`, `ihit` always 1, `id_stall=0` → `imemaddr` 0,4,8 on consecutive cycles; `PC_EN=1` each; `valid_out` with `pc_out` 0,4,8 one cycle later; `npc_out=pc_out+4`.
- Memory wait: `ihit` low for 3 cycles at `pcaddr=0x40` → `imemREN=1`, `imemaddr=0x40` stable, `PC_EN=0` for 3 cycles; on the 4th cycle push `instr=imemload`, `PC_EN=1`.
- Flush during wait: at `pcaddr=0x40`, `flush` with no `ihit` while the PC moves to `0x100` → DRAIN holds `imemaddr=0x40` until `ihit`, the data is discarded, then REQ at `0x100`. `valid_out` stays 0 throughout.
- Stall: `id_stall=1` for 4 cycles → with the macro, `count` reaches 2 and fetch stops; without it, `count` stays at 1. `pc_out` holds; no entry is lost or duplicated after release.
- Halt: `halt=1` on the `ihit` at `0x20` → push `0x20`, enter HALTED, `imemREN=0`. The buffer drains and `PC_EN` stays 0.
- Flush with full buffer and simultaneous `ihit` → `count=0`, data dropped, `PC_EN=1`, state IDLE.
